// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state, colour and VGA width definitions for the game core
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_WAIT_BEAT,
    ST_FETCH,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam int VGA_XW = 8;
  localparam int VGA_YW = 7;
  localparam int VGA_CW = 3;

  localparam logic [VGA_CW-1:0] BLACK = 3'd0;

  // Lane l is drawn in palette entry l+1 so that colour 0 always means empty.
  function automatic logic [VGA_CW-1:0] lane_colour(input int lane);
    return VGA_CW'(lane + 1);
  endfunction

endpackage

// File: rtl/box_pixel_scanner.sv
// rtl/box_pixel_scanner.sv - row/lane/py/px scan counters producing VGA pixel coordinates
// Ports:
//   clock, reset      rising-edge clock, synchronous active-low reset
//   go                restart the scan at row 0, lane 0, pixel (0,0)
//   advance           step to the next pixel (px fastest, then py, lane, row)
//   lane, row         box currently addressed
//   vga_x, vga_y      registered screen coordinates of the current pixel
//   last              current pixel is the final one of the pass
module box_pixel_scanner import game_pkg::*; #(
  parameter int LANES = 4,
  parameter int ROWS  = 8,
  parameter int BOX_W = 8,
  parameter int BOX_H = 8,
  parameter int X0    = 16,
  parameter int Y0    = 0,
  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int RW   = (ROWS  > 1) ? $clog2(ROWS)  : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic              advance,
  output logic [LW-1:0]     lane,
  output logic [RW-1:0]     row,
  output logic [VGA_XW-1:0] vga_x,
  output logic [VGA_YW-1:0] vga_y,
  output logic              last
);

  localparam int PXW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int PYW = (BOX_H > 1) ? $clog2(BOX_H) : 1;

  logic [PXW-1:0]    px_q, px_d;
  logic [PYW-1:0]    py_q, py_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic [RW-1:0]     row_q, row_d;
  logic [VGA_XW-1:0] x_q, x_d;
  logic [VGA_YW-1:0] y_q, y_d;

  always_comb begin
    px_d   = px_q;
    py_d   = py_q;
    lane_d = lane_q;
    row_d  = row_q;
    if (go) begin
      px_d   = '0;
      py_d   = '0;
      lane_d = '0;
      row_d  = '0;
    end else if (advance) begin
      if (px_q == PXW'(BOX_W - 1)) begin
        px_d = '0;
        if (py_q == PYW'(BOX_H - 1)) begin
          py_d = '0;
          if (lane_q == LW'(LANES - 1)) begin
            lane_d = '0;
            row_d  = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end else begin
          py_d = py_q + PYW'(1);
        end
      end else begin
        px_d = px_q + PXW'(1);
      end
    end
    // Coordinates follow the next counter values so they land on the same edge.
    x_d = VGA_XW'(X0 + int'(lane_d) * BOX_W + int'(px_d));
    y_d = VGA_YW'(Y0 + int'(row_d) * BOX_H + int'(py_d));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      px_q   <= '0;
      py_q   <= '0;
      lane_q <= '0;
      row_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      px_q   <= px_d;
      py_q   <= py_d;
      lane_q <= lane_d;
      row_q  <= row_d;
      if (go || advance) begin
        x_q <= x_d;
        y_q <= y_d;
      end
    end
  end

  assign lane  = lane_q;
  assign row   = row_q;
  assign vga_x = x_q;
  assign vga_y = y_q;
  assign last  = (px_q == PXW'(BOX_W - 1)) && (py_q == PYW'(BOX_H - 1)) &&
                 (lane_q == LW'(LANES - 1)) && (row_q == RW'(ROWS - 1));

endmodule

// File: rtl/lane_render_sequencer.sv
// rtl/lane_render_sequencer.sv - beat-driven note grid sequencer with scoring and VGA redraw
// Optional feature macro: MISS_PENALTY_EN (bottom-row notes without a hit subtract HIT_PTS).
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-low reset
//   start, pause                  song start pulse, beat timer freeze level
//   song_addr, song_data          song ROM address out, note bits back one cycle later
//   lane_hit                      synchronised player lane strobes
//   vga_x, vga_y, vga_colour,
//   vga_plot                      VGA adapter plot port
//   score, busy, song_done        running score and status
module lane_render_sequencer import game_pkg::*; #(
  parameter int LANES       = 4,
  parameter int ROWS        = 8,
  parameter int SONG_LEN    = 128,
  parameter int BOX_W       = 8,
  parameter int BOX_H       = 8,
  parameter int X0          = 16,
  parameter int Y0          = 0,
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int HIT_PTS     = 1,
  localparam int SONG_AW    = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  output logic [SONG_AW-1:0] song_addr,
  input  logic [LANES-1:0]   song_data,
  input  logic [LANES-1:0]   lane_hit,
  output logic [VGA_XW-1:0]  vga_x,
  output logic [VGA_YW-1:0]  vga_y,
  output logic [VGA_CW-1:0]  vga_colour,
  output logic               vga_plot,
  output logic [15:0]        score,
  output logic               busy,
  output logic               song_done
);

  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int RW  = (ROWS  > 1) ? $clog2(ROWS)  : 1;
  localparam int BIW = $clog2(SONG_LEN + ROWS + 1);
  localparam int CW  = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic [BIW-1:0]     beat_q, beat_d;
  // grid_q[r][l] is the note in lane l, row r; row ROWS-1 is the scoring row.
  logic [LANES-1:0]   grid_q [ROWS];
  logic [LANES-1:0]   grid_d [ROWS];
  logic [LANES-1:0]   latch_q, latch_d;
  logic [SONG_AW-1:0] addr_q, addr_d;
  logic [15:0]        score_q, score_d;
  logic               plot_q, busy_q, done_q;
  int                 net;

  logic               scan_go, scan_adv, scan_last;
  logic [LW-1:0]      scan_lane;
  logic [RW-1:0]      scan_row;

  box_pixel_scanner #(
    .LANES(LANES), .ROWS(ROWS), .BOX_W(BOX_W), .BOX_H(BOX_H), .X0(X0), .Y0(Y0)
  ) u_scan (
    .clock   (clock),
    .reset   (reset),
    .go      (scan_go),
    .advance (scan_adv),
    .lane    (scan_lane),
    .row     (scan_row),
    .vga_x   (vga_x),
    .vga_y   (vga_y),
    .last    (scan_last)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    beat_d   = beat_q;
    grid_d   = grid_q;
    latch_d  = latch_q | lane_hit;
    addr_d   = addr_q;
    score_d  = score_q;
    scan_go  = 1'b0;
    scan_adv = 1'b0;
    net      = int'(score_q);

    // A second expiry with a beat already pending simply leaves pend set.
    if ((state_q == ST_DRAW || state_q == ST_WAIT_BEAT) && !pause) begin
      if (cnt_q == CW'(BEAT_CYCLES - 1)) begin
        cnt_d  = '0;
        pend_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRAW;
          cnt_d   = '0;
          pend_d  = 1'b0;
          beat_d  = '0;
          grid_d  = '{default: '0};
          latch_d = '0;
          addr_d  = '0;
          score_d = '0;
          scan_go = 1'b1;
        end
      end
      ST_DRAW: begin
        scan_adv = 1'b1;
        if (scan_last) state_d = ST_WAIT_BEAT;
      end
      ST_WAIT_BEAT: begin
        if (pend_q) begin
          state_d = ST_FETCH;
          // Present the address during FETCH so the ROM answers in SHIFT.
          if (beat_q < BIW'(SONG_LEN)) addr_d = SONG_AW'(beat_q);
        end
      end
      ST_FETCH: state_d = ST_SHIFT;
      ST_SHIFT: begin
        pend_d = 1'b0;
        for (int l = 0; l < LANES; l++) begin
          if (grid_q[ROWS-1][l]) begin
            if (latch_q[l]) net = net + HIT_PTS;
`ifdef MISS_PENALTY_EN
            else            net = net - HIT_PTS;
`endif
          end
        end
        if (net > 65535)  score_d = 16'hFFFF;
        else if (net < 0) score_d = '0;
        else              score_d = 16'(net);
        for (int r = ROWS - 1; r > 0; r--) grid_d[r] = grid_q[r-1];
        grid_d[0] = (beat_q < BIW'(SONG_LEN)) ? song_data : '0;
        latch_d   = lane_hit;
        beat_d    = beat_q + BIW'(1);
        if (beat_d == BIW'(SONG_LEN + ROWS)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAW;
          scan_go = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      beat_q  <= '0;
      grid_q  <= '{default: '0};
      latch_q <= '0;
      addr_q  <= '0;
      score_q <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      beat_q  <= beat_d;
      grid_q  <= grid_d;
      latch_q <= latch_d;
      addr_q  <= addr_d;
      score_q <= score_d;
      plot_q  <= (state_d == ST_DRAW);
      busy_q  <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // Grid is frozen for the whole pass, so colour follows the registered scan position.
  assign vga_colour = (plot_q && grid_q[scan_row][scan_lane]) ? lane_colour(int'(scan_lane)) : BLACK;
  assign vga_plot   = plot_q;
  assign song_addr  = addr_q;
  assign score      = score_q;
  assign busy       = busy_q;
  assign song_done  = done_q;

endmodule

// File: tb/tb_lane_render_sequencer.sv
// tb/tb_lane_render_sequencer.sv - scoreboard bench for lane_render_sequencer
module tb_lane_render_sequencer;

  localparam int LANES    = 2;
  localparam int ROWS     = 3;
  localparam int BW       = 2;
  localparam int BH       = 2;
  localparam int SONG_LEN = 4;
  localparam int BEAT     = 40;
  localparam int X0       = 16;
  localparam int Y0       = 0;
  localparam int HIT      = 3;
  localparam int NPIX     = LANES * ROWS * BW * BH;
  localparam int NBEATS   = SONG_LEN + ROWS;

  logic             clock;
  logic             reset;
  logic             start;
  logic             pause;
  logic [1:0]       song_addr;
  logic [LANES-1:0] song_data;
  logic [LANES-1:0] lane_hit;
  logic [7:0]       vga_x;
  logic [6:0]       vga_y;
  logic [2:0]       vga_colour;
  logic             vga_plot;
  logic [15:0]      score;
  logic             busy;
  logic             song_done;

  lane_render_sequencer #(
    .LANES(LANES), .ROWS(ROWS), .SONG_LEN(SONG_LEN), .BOX_W(BW), .BOX_H(BH),
    .X0(X0), .Y0(Y0), .BEAT_CYCLES(BEAT), .HIT_PTS(HIT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .song_addr  (song_addr),
    .song_data  (song_data),
    .lane_hit   (lane_hit),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .score      (score),
    .busy       (busy),
    .song_done  (song_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [LANES-1:0] rom [SONG_LEN];
  always @(posedge clock) song_data <= rom[song_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  logic [17:0] exp_pix_q [$];
  int          exp_addr_q [$];
  int          exp_score_q [$];
  int          g [LANES][ROWS];
  int          m_score;
  bit          mon_en = 1'b0;
  bit          prev_plot = 1'b0;
  bit          prev_done = 1'b0;
  int          run_len = 0;

  // Monitor: consumes expected pixels, pass addresses and final scores as the DUT produces them.
  always @(negedge clock) begin
    if (mon_en) begin
      if (vga_plot) begin
        if (!prev_plot) begin
          if (exp_addr_q.size() == 0) check("unexpected_pass", 1, 0);
          else check("song_addr_at_pass", int'(song_addr), exp_addr_q.pop_front());
        end
        if (exp_pix_q.size() == 0) check("unexpected_pixel", 1, 0);
        else check("pixel_xyc", int'({vga_x, vga_y, vga_colour}), int'(exp_pix_q.pop_front()));
      end else if (prev_plot) begin
        check("pass_length", run_len, NPIX);
      end
      if (song_done && !prev_done) begin
        if (exp_score_q.size() == 0) check("unexpected_done", 1, 0);
        else check("final_score", int'(score), exp_score_q.pop_front());
      end
    end
    run_len   <= vga_plot ? (prev_plot ? run_len + 1 : 1) : 0;
    prev_plot <= vga_plot;
    prev_done <= song_done;
  end

  // Reference: every box drawn row by row, lane by lane, in lane colour l+1 when occupied.
  task automatic model_pass(input int addr);
    logic [2:0] col;
    for (int r = 0; r < ROWS; r++)
      for (int l = 0; l < LANES; l++)
        for (int py = 0; py < BH; py++)
          for (int px = 0; px < BW; px++) begin
            col = (g[l][r] != 0) ? 3'(l + 1) : 3'd0;
            exp_pix_q.push_back({8'(X0 + l * BW + px), 7'(Y0 + r * BH + py), col});
          end
    exp_addr_q.push_back(addr);
  endtask

  task automatic model_shift(input int b, input logic [LANES-1:0] h);
    int net = 0;
    for (int l = 0; l < LANES; l++) begin
      if (g[l][ROWS-1] != 0) begin
        if (h[l]) net += HIT;
`ifdef MISS_PENALTY_EN
        else      net -= HIT;
`endif
      end
    end
    m_score += net;
    if (m_score > 65535) m_score = 65535;
    if (m_score < 0)     m_score = 0;
    for (int l = 0; l < LANES; l++) begin
      for (int r = ROWS - 1; r > 0; r--) g[l][r] = g[l][r-1];
      g[l][0] = (b < SONG_LEN) ? int'(rom[b][l]) : 0;
    end
  endtask

  task automatic wait_plot(input logic lvl, input string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (vga_plot === lvl) return;
    end
    check({"timeout_", name}, 0, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (song_done === 1'b1) return;
    end
    check("timeout_song_done", 0, 1);
  endtask

  // hit_mode: 0 no hits, 1 all lanes, 2 random. One hit pulse is issued in each WAIT_BEAT window.
  task automatic run_song(input int hit_mode, input int pause_beat, input int restart_beat);
    int gap [NBEATS];
    int fall_cyc;
    logic [LANES-1:0] h;
    for (int l = 0; l < LANES; l++)
      for (int r = 0; r < ROWS; r++) g[l][r] = 0;
    m_score = 0;
    for (int b = 0; b < NBEATS; b++) gap[b] = 0;
    model_pass(0);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("score_cleared", int'(score), 0);
    check("done_cleared", int'(song_done), 0);
    wait_plot(1'b1, "first_pass");
    for (int b = 0; b < NBEATS; b++) begin
      wait_plot(1'b0, "pass_end");
      fall_cyc = cyc;
      h = (hit_mode == 0) ? '0 : (hit_mode == 1) ? '1 : LANES'($urandom);
      lane_hit = h;
      @(negedge clock) lane_hit = '0;
      if (b == restart_beat) begin
        start = 1'b1;
        @(negedge clock) start = 1'b0;
      end
      if (b == pause_beat) begin
        pause = 1'b1;
        repeat (100) @(negedge clock);
        pause = 1'b0;
      end
      model_shift(b, h);
      if (b < NBEATS - 1) begin
        model_pass((b < SONG_LEN) ? b : SONG_LEN - 1);
        wait_plot(1'b1, "pass_start");
        gap[b] = cyc - fall_cyc;
      end else begin
        exp_score_q.push_back(m_score);
        wait_done();
      end
    end
    if (pause_beat >= 2 && pause_beat < NBEATS - 1)
      check("pause_delay", gap[pause_beat], gap[1] + 100);
    repeat (3) @(negedge clock);
    check("busy_in_done", int'(busy), 0);
    check("plot_in_done", int'(vga_plot), 0);
    check("done_held", int'(song_done), 1);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    lane_hit = '0;
    rom[0] = 2'b01;
    rom[1] = 2'b10;
    rom[2] = 2'b00;
    rom[3] = 2'b11;
    repeat (3) @(negedge clock);
    check("rst_song_addr", int'(song_addr), 0);
    check("rst_vga_x", int'(vga_x), 0);
    check("rst_vga_y", int'(vga_y), 0);
    check("rst_vga_colour", int'(vga_colour), 0);
    check("rst_vga_plot", int'(vga_plot), 0);
    check("rst_score", int'(score), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_song_done", int'(song_done), 0);

    // Reset asserted in the middle of the first draw pass.
    reset = 1'b1;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (6) @(negedge clock);
    check("plot_mid_draw", int'(vga_plot), 1);
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_plot", int'(vga_plot), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_score", int'(score), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_after_rst_busy", int'(busy), 0);
    check("idle_after_rst_plot", int'(vga_plot), 0);
    mon_en = 1'b1;

    run_song(0, -1, -1);
    run_song(1, -1, 2);
    for (int s = 0; s < SONG_LEN; s++) rom[s] = LANES'($urandom);
    run_song(2, 3, -1);
    for (int s = 0; s < SONG_LEN; s++) rom[s] = LANES'($urandom);
    run_song(2, -1, 4);

    repeat (5) @(negedge clock);
    check("pixels_left", exp_pix_q.size(), 0);
    check("scores_left", exp_score_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
